// File: rtl/id_decode_stage.sv
// RV32I decode stage: combinational decode of the incoming word, registered output
// with a one-entry skid buffer so in_ready depends only on local state.
module id_decode_stage #(
  parameter int PC_W     = 32,
  parameter bit EN_M     = 1'b0,
  parameter bit EN_FENCE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [4:0]      ctl,
  output logic [3:0]      msg,
  output logic            mext,
  output logic [31:0]     imm,
  output logic [PC_W-1:0] pc,
  output logic            illegal,
  output logic            error_inst
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [4:0]      ctl;
    logic [3:0]      msg;
    logic            mext;
    logic [31:0]     imm;
    logic [PC_W-1:0] pc;
    logic            illegal;
  } payload_t;

  payload_t dec, out_reg, skid_reg;
  logic     out_valid_q, skid_valid_q, error_q;
  logic     accept, deliver;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
  logic [4:0]  ctl_sel;
  logic        alt, bad, mext_sel;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    imm_sel  = '0;
    ctl_sel  = '0;
    alt      = in_inst[30];
    bad      = 1'b0;
    mext_sel = 1'b0;
    case (opc)
      OPC_LUI:    begin imm_sel = imm_u; ctl_sel = 5'b01001; end
      OPC_AUIPC:  begin imm_sel = imm_u; ctl_sel = 5'b10001; end
      OPC_JAL:    begin imm_sel = imm_j; ctl_sel = 5'b00001; end
      OPC_JALR: begin
        imm_sel = imm_i;
        ctl_sel = 5'b00001;
        bad     = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        imm_sel = imm_b;
        ctl_sel = 5'b00001;
        bad     = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        imm_sel = imm_i;
        ctl_sel = 5'b00101;
        bad     = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        imm_sel = imm_s;
        ctl_sel = 5'b00011;
        bad     = (f3 > 3'b010);
      end
      OPC_OPIMM: begin
        // Only the shift-right group uses inst[30] as a real alt bit (srai vs srli)
        imm_sel = imm_i;
        ctl_sel = 5'b00001;
        alt     = (f3 == 3'b101) ? in_inst[30] : 1'b0;
        bad     = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                  ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
      end
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          bad = 1'b0;
        end else if ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
          bad = 1'b0;
        end else if (EN_M && (f7 == 7'b0000001)) begin
          mext_sel = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_MISC:   bad = !EN_FENCE;
      OPC_SYSTEM: bad = 1'b0;
      default:    bad = 1'b1;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.rs1     = in_inst[19:15];
    dec.rs2     = in_inst[24:20];
    dec.rd      = in_inst[11:7];
    dec.msg     = {alt, f3};
    dec.pc      = in_pc;
    dec.illegal = bad;
    if (!bad) begin
      dec.ctl  = ctl_sel;
      dec.mext = mext_sel;
      dec.imm  = imm_sel;
    end
  end

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid_q && out_ready;

  // The skid only fills while the output register is stalled, so it never
  // competes with a new accept when it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_reg      <= '0;
      skid_reg     <= '0;
      error_q      <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      if (accept && dec.illegal) begin
        error_q <= 1'b1;
      end
      if (!out_valid_q || deliver) begin
        if (skid_valid_q) begin
          out_reg      <= skid_reg;
          out_valid_q  <= 1'b1;
          skid_valid_q <= 1'b0;
        end else if (accept) begin
          out_reg     <= dec;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_reg     <= dec;
        skid_valid_q <= 1'b1;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign error_inst = error_q;
  assign rs1        = out_reg.rs1;
  assign rs2        = out_reg.rs2;
  assign rd         = out_reg.rd;
  assign ctl        = out_reg.ctl;
  assign msg        = out_reg.msg;
  assign mext       = out_reg.mext;
  assign imm        = out_reg.imm;
  assign pc         = out_reg.pc;
  assign illegal    = out_reg.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed decode/handshake scenarios plus a randomized
// run against a queue-based reference model, on a base instance and an RV32M/no-fence one.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready_a, out_valid_a, mext_a, illegal_a, error_a;
  logic [4:0]  rs1_a, rs2_a, rd_a, ctl_a;
  logic [3:0]  msg_a;
  logic [31:0] imm_a, pc_a;

  logic        in_ready_m, out_valid_m, mext_m, illegal_m, error_m;
  logic [4:0]  rs1_m, rs2_m, rd_m, ctl_m;
  logic [3:0]  msg_m;
  logic [31:0] imm_m, pc_m;

  logic [89:0] got_a, got_m;
  int tests = 0;
  int fails = 0;

  logic [6:0] opcs [0:10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                              7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  id_decode_stage #(.PC_W(32), .EN_M(1'b0), .EN_FENCE(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .rs1(rs1_a), .rs2(rs2_a), .rd(rd_a), .ctl(ctl_a), .msg(msg_a), .mext(mext_a),
    .imm(imm_a), .pc(pc_a), .illegal(illegal_a), .error_inst(error_a)
  );

  id_decode_stage #(.PC_W(32), .EN_M(1'b1), .EN_FENCE(1'b0)) dut_m (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid_m), .out_ready(out_ready),
    .rs1(rs1_m), .rs2(rs2_m), .rd(rd_m), .ctl(ctl_m), .msg(msg_m), .mext(mext_m),
    .imm(imm_m), .pc(pc_m), .illegal(illegal_m), .error_inst(error_m)
  );

  assign got_a = {rs1_a, rs2_a, rd_a, ctl_a, msg_a, mext_a, imm_a, pc_a, illegal_a};
  assign got_m = {rs1_m, rs2_m, rd_m, ctl_m, msg_m, mext_m, imm_m, pc_m, illegal_m};

  always #5 clk = ~clk;

  // Reference decode: immediates built arithmetically from field weights.
  function automatic logic [89:0] ref_decode(input logic [31:0] inst, input logic [31:0] pcv,
                                             input bit en_m, input bit en_fence);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] c;
    bit         bad, mx, alt;
    int         v;
    opc = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    c   = '0;
    bad = 1'b0;
    mx  = 1'b0;
    alt = inst[30];
    v   = 0;
    case (opc)
      7'h37: begin v = int'({inst[31:12], 12'h000}); c = 5'b01001; end
      7'h17: begin v = int'({inst[31:12], 12'h000}); c = 5'b10001; end
      7'h6F: begin
        v = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096
            - (inst[31] ? (1 << 20) : 0);
        c = 5'b00001;
      end
      7'h67: begin v = int'(inst[31:20]) - (inst[31] ? 4096 : 0); c = 5'b00001; bad = (f3 != 3'd0); end
      7'h63: begin
        v = int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2 + int'(inst[7]) * 2048
            - (inst[31] ? 4096 : 0);
        c = 5'b00001;
        bad = f3 inside {3'd2, 3'd3};
      end
      7'h03: begin v = int'(inst[31:20]) - (inst[31] ? 4096 : 0); c = 5'b00101; bad = f3 inside {3'd3, 3'd6, 3'd7}; end
      7'h23: begin
        v = int'(inst[31:25]) * 32 + int'(inst[11:7]) - (inst[31] ? 4096 : 0);
        c = 5'b00011;
        bad = (f3 > 3'd2);
      end
      7'h13: begin
        v = int'(inst[31:20]) - (inst[31] ? 4096 : 0);
        c = 5'b00001;
        alt = (f3 == 3'd5) ? inst[30] : 1'b0;
        bad = ((f3 == 3'd1) && (f7 != 7'h00)) || ((f3 == 3'd5) && !(f7 inside {7'h00, 7'h20}));
      end
      7'h33: begin
        mx  = en_m && (f7 == 7'h01);
        bad = !((f7 == 7'h00) || ((f7 == 7'h20) && (f3 inside {3'd0, 3'd5})) || mx);
      end
      7'h0F: bad = !en_fence;
      7'h73: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) bad = 1'b1;
    if (bad) begin
      c  = '0;
      mx = 1'b0;
      v  = 0;
    end
    return {inst[19:15], inst[24:20], inst[11:7], c, alt, f3, mx, 32'(v), pcv, bad};
  endfunction

  task automatic send_one(input logic [31:0] inst, input logic [31:0] pcv);
    @(negedge clk);
    in_valid  = 1'b1;
    in_inst   = inst;
    in_pc     = pcv;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h40; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_handshake: got valid=%b ready=%b expected valid=0 ready=1", out_valid_a, in_ready_a);
    end
    tests++;
    if (got_a !== '0 || got_m !== '0) begin
      fails++; $display("[TB] FAIL reset_payload: got %h / %h expected all zero", got_a, got_m);
    end
    tests++;
    if (error_a !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_error: got %b expected 0", error_a);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid_a !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_discard: got out_valid=%b expected 0", out_valid_a);
    end
  endtask

  task automatic test_flush;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h100;
    @(negedge clk);
    in_inst = 32'h00200113; in_pc = 32'h104;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1) begin
      fails++; $display("[TB] FAIL flush_full: got ready=%b valid=%b expected ready=0 valid=1", in_ready_a, out_valid_a);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      fails++; $display("[TB] FAIL flush_clear: got valid=%b ready=%b expected valid=0 ready=1", out_valid_a, in_ready_a);
    end
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'hFFFFFFFF;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    tests++;
    if (out_valid_a !== 1'b0 || error_a !== 1'b0) begin
      fails++; $display("[TB] FAIL flush_discard: got valid=%b error=%b expected 0 0", out_valid_a, error_a);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_addi;
    send_one(32'hFFF00093, 32'h200);
    tests++;
    if (out_valid_a !== 1'b1 || imm_a !== 32'hFFFFFFFF || ctl_a !== 5'b00001) begin
      fails++; $display("[TB] FAIL addi_imm_ctl: got valid=%b imm=%h ctl=%b expected 1 ffffffff 00001", out_valid_a, imm_a, ctl_a);
    end
    tests++;
    if (msg_a !== 4'b0000 || rd_a !== 5'd1 || illegal_a !== 1'b0 || pc_a !== 32'h200) begin
      fails++; $display("[TB] FAIL addi_fields: got msg=%b rd=%0d ill=%b pc=%h expected 0000 1 0 200", msg_a, rd_a, illegal_a, pc_a);
    end
  endtask

  task automatic test_srai;
    send_one(32'h4041D113, 32'h300);
    tests++;
    if (msg_a !== 4'b1101 || imm_a[11:0] !== 12'h404 || illegal_a !== 1'b0) begin
      fails++; $display("[TB] FAIL srai: got msg=%b imm=%h ill=%b expected 1101 404 0", msg_a, imm_a[11:0], illegal_a);
    end
    send_one(32'h4041A113, 32'h304);
    tests++;
    if (msg_a !== 4'b0010 || error_a !== 1'b0) begin
      fails++; $display("[TB] FAIL slti_alt: got msg=%b err=%b expected 0010 0", msg_a, error_a);
    end
    send_one(32'h6041D113, 32'h308);
    tests++;
    if (illegal_a !== 1'b1 || ctl_a !== 5'd0 || imm_a !== 32'd0 || error_a !== 1'b1) begin
      fails++; $display("[TB] FAIL srai_bad: got ill=%b ctl=%b imm=%h err=%b expected 1 0 0 1", illegal_a, ctl_a, imm_a, error_a);
    end
    @(negedge clk);
    tests++;
    if (error_a !== 1'b1) begin
      fails++; $display("[TB] FAIL error_sticky: got %b expected 1", error_a);
    end
  endtask

  task automatic test_branch_lui;
    send_one(32'hFE000EE3, 32'h400);
    tests++;
    if (imm_a !== 32'hFFFFFFFC || ctl_a !== 5'b00001 || illegal_a !== 1'b0) begin
      fails++; $display("[TB] FAIL beq: got imm=%h ctl=%b ill=%b expected fffffffc 00001 0", imm_a, ctl_a, illegal_a);
    end
    send_one(32'h123452B7, 32'h404);
    tests++;
    if (imm_a !== 32'h12345000 || ctl_a !== 5'b01001 || rd_a !== 5'd5) begin
      fails++; $display("[TB] FAIL lui: got imm=%h ctl=%b rd=%0d expected 12345000 01001 5", imm_a, ctl_a, rd_a);
    end
  endtask

  task automatic test_mext;
    send_one(32'h023100B3, 32'h500);
    tests++;
    if (illegal_a !== 1'b1 || ctl_a !== 5'd0 || mext_a !== 1'b0) begin
      fails++; $display("[TB] FAIL mul_base: got ill=%b ctl=%b mext=%b expected 1 0 0", illegal_a, ctl_a, mext_a);
    end
    tests++;
    if (mext_m !== 1'b1 || msg_m !== 4'b0000 || illegal_m !== 1'b0) begin
      fails++; $display("[TB] FAIL mul_m: got mext=%b msg=%b ill=%b expected 1 0000 0", mext_m, msg_m, illegal_m);
    end
    send_one(32'h0000000F, 32'h504);
    tests++;
    if (illegal_a !== 1'b0 || illegal_m !== 1'b1) begin
      fails++; $display("[TB] FAIL fence: got base=%b nofence=%b expected 0 1", illegal_a, illegal_m);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h10;
    @(negedge clk);
    tests++;
    if (in_ready_a !== 1'b1) begin
      fails++; $display("[TB] FAIL bp_ready1: got %b expected 1", in_ready_a);
    end
    in_inst = 32'h00200113; in_pc = 32'h14;
    @(negedge clk);
    tests++;
    if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || rd_a !== 5'd1) begin
      fails++; $display("[TB] FAIL bp_full: got ready=%b valid=%b rd=%0d expected 0 1 1", in_ready_a, out_valid_a, rd_a);
    end
    in_inst = 32'h00300193; in_pc = 32'h18;
    @(negedge clk);
    out_ready = 1'b1;
    tests++;
    if (out_valid_a !== 1'b1 || rd_a !== 5'd1 || pc_a !== 32'h10 || in_ready_a !== 1'b0) begin
      fails++; $display("[TB] FAIL bp_first: got valid=%b rd=%0d pc=%h ready=%b expected 1 1 10 0", out_valid_a, rd_a, pc_a, in_ready_a);
    end
    @(negedge clk);
    tests++;
    if (out_valid_a !== 1'b1 || rd_a !== 5'd2 || pc_a !== 32'h14 || in_ready_a !== 1'b1) begin
      fails++; $display("[TB] FAIL bp_second: got valid=%b rd=%0d pc=%h ready=%b expected 1 2 14 1", out_valid_a, rd_a, pc_a, in_ready_a);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (out_valid_a !== 1'b1 || rd_a !== 5'd3 || pc_a !== 32'h18) begin
      fails++; $display("[TB] FAIL bp_third: got valid=%b rd=%0d pc=%h expected 1 3 18", out_valid_a, rd_a, pc_a);
    end
    @(negedge clk);
    tests++;
    if (out_valid_a !== 1'b0) begin
      fails++; $display("[TB] FAIL bp_drained: got valid=%b expected 0", out_valid_a);
    end
  endtask

  task automatic test_rst_midop;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFFFFFFF; in_pc = 32'h600;
    @(negedge clk);
    in_inst = 32'h00100093; in_pc = 32'h604;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (in_ready_a !== 1'b0 || error_a !== 1'b1) begin
      fails++; $display("[TB] FAIL rst_setup: got ready=%b err=%b expected 0 1", in_ready_a, error_a);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || error_a !== 1'b0 || got_a !== '0) begin
      fails++; $display("[TB] FAIL rst_midop: got valid=%b ready=%b err=%b payload=%h expected 0 1 0 0",
                        out_valid_a, in_ready_a, error_a, got_a);
    end
    rst = 1'b0;
  endtask

  task automatic test_random;
    logic [63:0] q[$];
    logic [89:0] exp_a, exp_m;
    logic [6:0]  opc, f7;
    logic [31:0] inst;
    bit          err_a, err_m, exp_rdy, exp_val;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    err_a = 1'b0;
    err_m = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      exp_rdy = (q.size() < 2);
      exp_val = (q.size() > 0);
      tests++;
      if (in_ready_a !== exp_rdy || in_ready_m !== exp_rdy) begin
        fails++; $display("[TB] FAIL rnd_ready cyc %0d: got %b/%b expected %b", cyc, in_ready_a, in_ready_m, exp_rdy);
      end
      tests++;
      if (out_valid_a !== exp_val || out_valid_m !== exp_val) begin
        fails++; $display("[TB] FAIL rnd_valid cyc %0d: got %b/%b expected %b", cyc, out_valid_a, out_valid_m, exp_val);
      end
      if (exp_val) begin
        exp_a = ref_decode(q[0][63:32], q[0][31:0], 1'b0, 1'b1);
        exp_m = ref_decode(q[0][63:32], q[0][31:0], 1'b1, 1'b0);
        tests++;
        if (got_a !== exp_a) begin
          fails++; $display("[TB] FAIL rnd_payload cyc %0d inst %h: got %h expected %h", cyc, q[0][63:32], got_a, exp_a);
        end
        tests++;
        if (got_m !== exp_m) begin
          fails++; $display("[TB] FAIL rnd_payload_m cyc %0d inst %h: got %h expected %h", cyc, q[0][63:32], got_m, exp_m);
        end
      end
      tests++;
      if (error_a !== err_a || error_m !== err_m) begin
        fails++; $display("[TB] FAIL rnd_error cyc %0d: got %b/%b expected %b/%b", cyc, error_a, error_m, err_a, err_m);
      end

      opc = ($urandom_range(0, 15) < 11) ? opcs[$urandom_range(0, 10)] : 7'($urandom);
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      inst = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
      if ($urandom_range(0, 15) == 0) inst = $urandom;
      in_inst   = inst;
      in_pc     = $urandom & 32'hFFFF_FFFC;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);

      if (flush) begin
        q.delete();
      end else begin
        if (exp_val && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy) begin
          q.push_back({inst, in_pc});
          err_a = err_a | ref_decode(inst, in_pc, 1'b0, 1'b1)[0];
          err_m = err_m | ref_decode(inst, in_pc, 1'b1, 1'b0)[0];
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    test_reset();
    test_flush();
    test_addi();
    test_srai();
    test_branch_lui();
    test_mext();
    test_back_to_back();
    test_rst_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
